// File: rtl/qos_bar_renderer.sv
// Four-queue occupancy bar renderer for a 640x480 VGA pipeline (two-stage, double-buffered).
// Optional background grid overlay is enabled by defining GRID_OVERLAY_EN.
module qos_bar_renderer #(
    parameter logic [7:0]  THRESH     = 8'd240,
    parameter int unsigned BAR_MARGIN = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        new_frame,
    input  logic        occ_wr,
    input  logic [1:0]  occ_sel,
    input  logic [7:0]  occ_data,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [15:0] frame_cnt
);

    localparam logic [9:0] COL_W     = 10'd160;
    localparam logic [9:0] LAST_ROW  = 10'd479;
    localparam logic [7:0] MARGIN_LO = BAR_MARGIN[7:0];
    localparam logic [7:0] MARGIN_HI = 8'(159 - BAR_MARGIN);

    // Occupancy banks: staging is written freely, active only changes at frame boundaries.
    logic [3:0][7:0] staging_q;
    logic [3:0][7:0] active_q;
    logic [15:0]     frame_cnt_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            staging_q   <= '0;
            active_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (new_frame) begin
                active_q    <= staging_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (occ_wr) begin
                staging_q[occ_sel] <= occ_data;
            end
        end
    end

    // Stage 1: column decode, offset and bar row test.
    logic [1:0] col_d;
    logic [9:0] col_base;
    logic [9:0] off_full;
    logic [7:0] col_occ;
    logic [9:0] rows_up;
    logic       row_hit_d;
    logic       alarm_d;

    always_comb begin
        col_d    = 2'd3;
        col_base = 3 * COL_W;
        if (x < COL_W) begin
            col_d    = 2'd0;
            col_base = 10'd0;
        end else if (x < 2 * COL_W) begin
            col_d    = 2'd1;
            col_base = COL_W;
        end else if (x < 3 * COL_W) begin
            col_d    = 2'd2;
            col_base = 2 * COL_W;
        end
        off_full  = x - col_base;
        col_occ   = active_q[col_d];
        rows_up   = '0;
        row_hit_d = 1'b0;
        // 479-y only formed inside the active area, so it cannot underflow.
        if (video_on) begin
            rows_up   = LAST_ROW - y;
            row_hit_d = (off_full < COL_W) && (rows_up < {2'b00, col_occ});
        end
        alarm_d = (col_occ >= THRESH);
    end

    logic [1:0] col_q;
    logic [7:0] off_q;
    logic       row_hit_q;
    logic       alarm_q;
    logic       von_q;
    logic       hs_q;
    logic       vs_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            col_q     <= '0;
            off_q     <= '0;
            row_hit_q <= 1'b0;
            alarm_q   <= 1'b0;
            von_q     <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            col_q     <= col_d;
            off_q     <= off_full[7:0];
            row_hit_q <= row_hit_d;
            alarm_q   <= alarm_d;
            von_q     <= video_on;
            hs_q      <= hsync_in;
            vs_q      <= vsync_in;
        end
    end

`ifdef GRID_OVERLAY_EN
    logic grid_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            grid_q <= 1'b0;
        end else begin
            grid_q <= (x[5:0] == 6'd0) || (y[5:0] == 6'd0);
        end
    end
`endif

    // Stage 2: margin window and colour selection.
    logic        bar_hit;
    logic [11:0] rgb_d;

    always_comb begin
        bar_hit = row_hit_q && (off_q >= MARGIN_LO) && (off_q <= MARGIN_HI);
        rgb_d   = 12'h000;
        if (von_q) begin
            if (bar_hit) begin
                if (alarm_q) begin
                    rgb_d = 12'hFFF;
                end else begin
                    unique case (col_q)
                        2'd0: rgb_d = 12'hF00;
                        2'd1: rgb_d = 12'h0F0;
                        2'd2: rgb_d = 12'h00F;
                        2'd3: rgb_d = 12'hFF0;
                        default: rgb_d = 12'h000;
                    endcase
                end
            end else begin
`ifdef GRID_OVERLAY_EN
                rgb_d = grid_q ? 12'h444 : 12'h000;
`else
                rgb_d = 12'h000;
`endif
            end
        end
    end

    logic [11:0] rgb_q;
    logic        hsync_q;
    logic        vsync_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rgb_q   <= 12'h000;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hs_q;
            vsync_q <= vs_q;
        end
    end

    assign rgb       = rgb_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/qos_bar_renderer.md
QOS_BAR_RENDERER -- requirements
Module: qos_bar_renderer

Interface
REQ-001 Parameter THRESH, default 8'd240; occupancy at or above this value draws the bar in alarm colour.
REQ-002 Parameter BAR_MARGIN, default 16; blank pixels on each side of a bar inside its 160-px column.
REQ-003 CLK  input  1  25 MHz pixel clock, the same clock that drives the sync generator; rising-edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 x  input  10  current pixel column from the sync generator.
REQ-006 y  input  10  current pixel row from the sync generator.
REQ-007 video_on  input  1  high inside the 640x480 active area.
REQ-008 hsync_in  input  1  horizontal sync from the sync generator, active-low.
REQ-009 vsync_in  input  1  vertical sync from the sync generator, active-low.
REQ-010 new_frame  input  1  one-cycle pulse on the last pixel of a frame (x=799, y=524).
REQ-011 occ_wr  input  1  write strobe for the staging occupancy register.
REQ-012 occ_sel  input  2  queue index (0-3) for the write.
REQ-013 occ_data  input  8  queue occupancy value for the write.
REQ-014 rgb  output  12  pixel colour, {R[3:0],G[3:0],B[3:0]}.
REQ-015 hsync_out  output  1  hsync_in delayed to align with rgb.
REQ-016 vsync_out  output  1  vsync_in delayed to align with rgb.
REQ-017 frame_cnt  output  16  count of new_frame pulses since reset; wraps from 0xFFFF to 0.

Function
REQ-018 Two banks of four 8-bit registers: staging (written by occ_wr) and active (used for drawing).
REQ-019 occ_wr high: staging[occ_sel] <= occ_data on the next edge; the active bank is unaffected.
REQ-020 new_frame high: active <= staging, all four entries together.
REQ-021 occ_wr and new_frame in the same cycle: active receives the pre-write staging value; the write lands in staging and shows one frame later.
REQ-022 Active values stay constant for a whole frame; no mid-frame tearing.
REQ-023 Pipeline is two stages; rgb, hsync_out and vsync_out correspond to the x/y/video_on/syncs presented 2 cycles earlier.
REQ-024 Stage 1 registers the column index q = x/160 (0-3) and the x offset within the column (x mod 160).
REQ-025 Stage 1 also registers the bar-hit flag: offset in [BAR_MARGIN, 159-BAR_MARGIN] and (479 - y) < active[q].
REQ-026 Stage 1 registers video_on and both syncs alongside the above.
REQ-027 Stage 2 colour, delayed video_on low: rgb = 12'h000.
REQ-028 Stage 2 colour, bar hit with active[q] >= THRESH: rgb = 12'hFFF.
REQ-029 Stage 2 colour, bar hit below THRESH: q0 12'hF00, q1 12'h0F0, q2 12'h00F, q3 12'hFF0.
REQ-030 Stage 2 colour, otherwise: background (REQ-035).
REQ-031 Occupancy 0 draws no bar pixels. Occupancy 255 fills rows 225-479.
REQ-032 Bar arithmetic is unsigned 10-bit. 479-y is evaluated only while video_on is high, so there is no underflow.
REQ-033 frame_cnt increments on the cycle after new_frame is sampled.

Reset
REQ-034 Reset, asserted asynchronously, clears staging, active, all pipeline registers and frame_cnt. During reset: rgb=12'h000, hsync_out=1, vsync_out=1. The first valid pixel appears 2 cycles after reset deasserts; a reset mid-frame discards the frame.

Configuration
REQ-035 Macro GRID_OVERLAY_EN.
- Defined: non-bar active pixels with y[5:0]==0 or x[5:0]==0 are rgb=12'h444; other background pixels are 12'h000.
- Undefined: all background pixels are 12'h000, and no grid logic is synthesised.

Verification
REQ-036 Reset mid-line, then release. Stimulus: occ_wr sel=0 data=100, then new_frame. Required: bar 0 red (12'hF00) at rows 380-479, columns 16-143; no bar pixel at row 379.
REQ-037 Stimulus: occ_wr sel=2 data=50 mid-frame, with no new_frame yet. Required: column 2 still draws the old value until the next new_frame; afterwards 12'h00F at rows 430-479.
REQ-038 Stimulus: occ_wr sel=1 data=200 in the same cycle as new_frame. Required: the following frame shows the old value; the frame after that shows bar 1 at rows 280-479.
REQ-039 Stimulus: sel=3 data=240, then data=239, with THRESH=240. Required: bar 3 is 12'hFFF in the first frame and 12'hFF0 in the next.
REQ-040 Stimulus: hsync_in toggling at x=656. Required: hsync_out toggles exactly 2 cycles later, and rgb is 0 when video_on was low 2 cycles earlier.
REQ-041 Stimulus: GRID_OVERLAY_EN defined, all occ=0. Required: pixel (64,10) and row y=128 read 12'h444; pixel (65,65) reads 12'h000. frame_cnt reaches 3 after 3 new_frame pulses.
